// File: rtl/ddr_rw_arbiter.sv
// Two-requester DDR command arbiter.
// Reads go to the raddr FIFO with an owner tag. Writes are 2-beat bursts:
// beat 0 carries the address and first data word, beat 1 only data.
// Requesters are served round-robin. A direction policy caps how many grants
// in a row go to one direction while the other direction is waiting.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_INIT | PHY not ready; no ready asserted, no grants
// IDLE      | arbitrate; reads complete in one handshake
// WR_B1     | write beat 0 taken; waiting for owner's beat 1 (busy=1)
module ddr_rw_arbiter #(
   parameter int ADDR_W       = 30,
   parameter int DATA_W       = 256,
   parameter int MAX_SAME_DIR = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              phy_init_done,

   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,

   output logic              raddr_fifo_wr_en,
   output logic [ADDR_W-1:0] raddr_fifo_din,
   input  logic              raddr_fifo_full,

   output logic              rtag_fifo_wr_en,
   output logic              rtag_fifo_din,
   input  logic              rtag_fifo_full,

   output logic              waddr_fifo_wr_en,
   output logic [ADDR_W-1:0] waddr_fifo_din,
   input  logic              waddr_fifo_full,

   output logic              wdata_fifo_wr_en,
   output logic [DATA_W-1:0] wdata_fifo_din,
   input  logic              wdata_fifo_afull,

   output logic              busy
);

   localparam int              CNT_W   = $clog2(MAX_SAME_DIR + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SAME_DIR);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // direction encoding matches reqN_we: 0 = read, 1 = write
   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      IDLE      = 2'd1,
      WR_B1     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              cur_dir_q, cur_dir_d;
   logic [CNT_W-1:0]  same_cnt_q, same_cnt_d;
   logic              owner_q, owner_d;

   logic              rpush_q, rpush_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              rtag_q, rtag_d;
   logic              wapush_q, wapush_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              wdpush_q, wdpush_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              rd_ok, wr_ok;
   logic              elig0, elig1;
   logic              opp_pend, pref_dir;
   logic              cand0, cand1;
   logic              gnt_vld, gnt_id, gnt_we;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_wdata;
   logic              own_valid;
   logic [DATA_W-1:0] own_wdata;

   // Arbitration: eligibility, direction preference, round-robin pick
   always_comb begin
      rd_ok = ~raddr_fifo_full & ~rtag_fifo_full;
      wr_ok = ~waddr_fifo_full & ~wdata_fifo_afull;
      elig0 = req0_valid & (req0_we ? wr_ok : rd_ok);
      elig1 = req1_valid & (req1_we ? wr_ok : rd_ok);

      // the opposite direction counts as waiting as soon as it is valid,
      // even if its FIFO is currently full
      opp_pend = (req0_valid & (req0_we != cur_dir_q)) |
                 (req1_valid & (req1_we != cur_dir_q));
      pref_dir = (opp_pend && (same_cnt_q >= CNT_MAX)) ? ~cur_dir_q : cur_dir_q;

      cand0 = elig0 & (req0_we == pref_dir);
      cand1 = elig1 & (req1_we == pref_dir);
      if (!cand0 && !cand1) begin
         cand0 = elig0;
         cand1 = elig1;
      end

      gnt_vld   = (state_q == IDLE) & phy_init_done & (cand0 | cand1);
      gnt_id    = rr_ptr_q ? cand1 : ~cand0;
      gnt_we    = gnt_id ? req1_we    : req0_we;
      gnt_addr  = gnt_id ? req1_addr  : req0_addr;
      gnt_wdata = gnt_id ? req1_wdata : req0_wdata;

      own_valid = owner_q ? req1_valid : req0_valid;
      own_wdata = owner_q ? req1_wdata : req0_wdata;
   end

   // Ready: grant in IDLE, burst owner only in WR_B1
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = gnt_vld & ~gnt_id;
            req1_ready = gnt_vld &  gnt_id;
         end
         WR_B1: begin
            req0_ready = ~owner_q;
            req1_ready =  owner_q;
         end
         default: begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
         end
      endcase
   end

   // Next state, arbitration bookkeeping and FIFO push staging
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cur_dir_d  = cur_dir_q;
      same_cnt_d = same_cnt_q;
      owner_d    = owner_q;

      rpush_d  = 1'b0;
      wapush_d = 1'b0;
      wdpush_d = 1'b0;
      raddr_d  = raddr_q;
      rtag_d   = rtag_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;

      case (state_q)
         WAIT_INIT: begin
            if (phy_init_done) state_d = IDLE;
         end
         IDLE: begin
            if (!phy_init_done) begin
               state_d = WAIT_INIT;
            end else if (gnt_vld) begin
               rr_ptr_d = ~gnt_id;
               if (gnt_we == cur_dir_q) begin
                  if (same_cnt_q < CNT_MAX) same_cnt_d = same_cnt_q + CNT_ONE;
               end else begin
                  cur_dir_d  = gnt_we;
                  same_cnt_d = CNT_ONE;
               end
               if (gnt_we) begin
                  wapush_d = 1'b1;
                  waddr_d  = gnt_addr;
                  wdpush_d = 1'b1;
                  wdata_d  = gnt_wdata;
                  owner_d  = gnt_id;
                  state_d  = WR_B1;
               end else begin
                  rpush_d = 1'b1;
                  raddr_d = gnt_addr;
                  rtag_d  = gnt_id;
               end
            end
         end
         WR_B1: begin
            // space for this beat was reserved by afull at beat 0
            if (own_valid) begin
               wdpush_d = 1'b1;
               wdata_d  = own_wdata;
               state_d  = phy_init_done ? IDLE : WAIT_INIT;
            end
         end
         default: state_d = WAIT_INIT;
      endcase
   end

   // State and output registers; reset clears every push and data bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_INIT;
         rr_ptr_q   <= 1'b0;
         cur_dir_q  <= 1'b0;
         same_cnt_q <= '0;
         owner_q    <= 1'b0;
         rpush_q    <= 1'b0;
         raddr_q    <= '0;
         rtag_q     <= 1'b0;
         wapush_q   <= 1'b0;
         waddr_q    <= '0;
         wdpush_q   <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cur_dir_q  <= cur_dir_d;
         same_cnt_q <= same_cnt_d;
         owner_q    <= owner_d;
         rpush_q    <= rpush_d;
         raddr_q    <= raddr_d;
         rtag_q     <= rtag_d;
         wapush_q   <= wapush_d;
         waddr_q    <= waddr_d;
         wdpush_q   <= wdpush_d;
         wdata_q    <= wdata_d;
      end
   end

   assign raddr_fifo_wr_en = rpush_q;
   assign raddr_fifo_din   = raddr_q;
   assign rtag_fifo_wr_en  = rpush_q;
   assign rtag_fifo_din    = rtag_q;
   assign waddr_fifo_wr_en = wapush_q;
   assign waddr_fifo_din   = waddr_q;
   assign wdata_fifo_wr_en = wdpush_q;
   assign wdata_fifo_din   = wdata_q;
   assign busy             = (state_q == WR_B1);

endmodule
